// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl_pkg
// Purpose  : Shared types and constants for the core run controller.
//            run_state_t - FSM state encoding, also visible on state_o
//            run_cmd_t   - host command opcodes on the command handshake
// Revision : 1.0 - initial release
// ============================================================================
package core_ctrl_pkg;

    localparam int unsigned PIPE_DEPTH_DEFAULT = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } run_state_t;

    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_STOP = 2'b11
    } run_cmd_t;

    // Counter width able to hold a drain length of up to 'depth' cycles.
    function automatic int unsigned drain_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_run_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : core_run_controller_if
// Purpose  : Host command handshake of the run controller.
//            cmd_valid - host presents a command
//            cmd_op    - command opcode (run_cmd_t)
//            cmd_ready - controller accepts (transfer on valid & ready)
//            master    - host side, slave - controller side
// Revision : 1.0 - initial release
// ============================================================================
interface core_run_controller_if;
    import core_ctrl_pkg::*;

    logic     cmd_valid;
    run_cmd_t cmd_op;
    logic     cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready
    );

endinterface
`default_nettype wire

// File: rtl/pipe_drain_timer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_drain_timer
// Purpose  : Loadable down-counter timing a pipeline drain.
//            clk_i      - clock
//            rst_ni     - asynchronous active-low reset (count -> 0)
//            load_i     - load load_val_i this cycle (wins over decrement)
//            load_val_i - drain length in cycles
//            done_o     - high while the count is 1 (last drain cycle)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_drain_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    output logic                  done_o
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Saturates at zero so an idle timer never wraps into a false done.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - c_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == c_ONE);

endmodule
`default_nettype wire

// File: rtl/core_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : core_run_controller
// Purpose  : Run/step/halt sequencer for the pipelined core. Takes host
//            commands, folds in hazard/redirect requests, drains the
//            pipeline on stop/ecall and reports status.
// Ports    : clk_i, rst_ni          - clock, async active-low reset
//            cmd (slave)            - host command handshake
//            halt_detected_i        - ecall/halt decoded in ID
//            load_hazard_i          - load-use stall request
//            branch_taken_i         - redirect resolved in EX
//            pc_en_o, if_id_en_o    - fetch-stage enables
//            flush_if_id_o          - IF/ID loads a NOP
//            force_nop_o            - kill the ID instruction
//            state_o, busy_o        - FSM state and RUN/STEP/DRAIN flag
//            halted_o               - ecall retired (terminal)
// Options  : CORE_RUN_PERF_COUNTERS_EN adds cycle_count_o / stall_count_o.
// Revision : 1.0 - initial release
// ============================================================================
module core_run_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEFAULT,
    parameter int unsigned CNT_W      = 32
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    core_run_controller_if.slave       cmd,
    input  wire logic                  halt_detected_i,
    input  wire logic                  load_hazard_i,
    input  wire logic                  branch_taken_i,
    output logic                       pc_en_o,
    output logic                       if_id_en_o,
    output logic                       flush_if_id_o,
    output logic                       force_nop_o,
    output logic [2:0]                 state_o,
    output logic                       busy_o,
    output logic                       halted_o
`ifdef CORE_RUN_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]           cycle_count_o,
    output logic [CNT_W-1:0]           stall_count_o
`endif
);

    localparam int unsigned      c_DRAIN_W   = drain_cnt_width(PIPE_DEPTH);
    // Stop/halt: the instructions already past ID still have to retire.
    localparam logic [c_DRAIN_W-1:0] c_LOAD_STOP = c_DRAIN_W'(PIPE_DEPTH - 2);
    // Step: the single fetched instruction walks the whole pipe.
    localparam logic [c_DRAIN_W-1:0] c_LOAD_STEP = c_DRAIN_W'(PIPE_DEPTH - 1);

    generate
        if (PIPE_DEPTH < 3 || CNT_W < 1) begin : g_param_check
            $error("core_run_controller: PIPE_DEPTH must be >= 3 and CNT_W >= 1");
        end
    endgenerate

    run_state_t               state_q;
    run_state_t               state_d;
    logic                     halt_seen_q;
    logic                     halt_seen_d;
    logic                     w_load;
    logic [c_DRAIN_W-1:0]     w_load_val;
    logic                     w_drain_done;
    logic                     w_cmd_ready;
    logic                     w_stop;

    // Ready depends on state only, so valid alone marks an accepted command
    // in the states that are ready.
    assign w_stop = cmd.cmd_valid && (cmd.cmd_op == CMD_STOP);

    always_comb begin
        state_d       = state_q;
        halt_seen_d   = halt_seen_q;
        w_load        = 1'b0;
        w_load_val    = c_LOAD_STOP;
        w_cmd_ready   = 1'b0;
        pc_en_o       = 1'b0;
        if_id_en_o    = 1'b0;
        flush_if_id_o = 1'b0;
        force_nop_o   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd.cmd_valid && cmd.cmd_op == CMD_RUN) begin
                    state_d = ST_RUN;
                end else if (cmd.cmd_valid && cmd.cmd_op == CMD_STEP) begin
                    state_d = ST_STEP;
                end
            end

            ST_RUN: begin
                w_cmd_ready = 1'b1;
                if (branch_taken_i) begin
                    // Redirect: the ID instruction is wrong-path, so a halt
                    // decoded there is discarded.
                    pc_en_o       = 1'b1;
                    if_id_en_o    = 1'b1;
                    flush_if_id_o = 1'b1;
                    force_nop_o   = 1'b1;
                    if (w_stop) begin
                        w_load  = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end else if (halt_detected_i || w_stop) begin
                    // The ID instruction (ecall included) proceeds; fetch
                    // freezes and IF/ID fills with bubbles.
                    if_id_en_o    = 1'b1;
                    flush_if_id_o = 1'b1;
                    force_nop_o   = 1'b0;
                    if (halt_detected_i) begin
                        halt_seen_d = 1'b1;
                    end
                    w_load  = 1'b1;
                    state_d = ST_DRAIN;
                end else if (load_hazard_i) begin
                    force_nop_o = 1'b1;
                end else begin
                    pc_en_o     = 1'b1;
                    if_id_en_o  = 1'b1;
                    force_nop_o = 1'b0;
                end
            end

            ST_STEP: begin
                pc_en_o     = 1'b1;
                if_id_en_o  = 1'b1;
                force_nop_o = 1'b1;
                w_load      = 1'b1;
                w_load_val  = c_LOAD_STEP;
                state_d     = ST_DRAIN;
            end

            ST_DRAIN: begin
                if_id_en_o    = 1'b1;
                flush_if_id_o = 1'b1;
                force_nop_o   = 1'b0;
                if (branch_taken_i) begin
                    // Capture the redirect target so a later run resumes there.
                    pc_en_o     = 1'b1;
                    force_nop_o = 1'b1;
                end else if (halt_detected_i) begin
                    halt_seen_d = 1'b1;
                end
                if (w_drain_done) begin
                    state_d = halt_seen_d ? ST_HALTED : ST_IDLE;
                end
            end

            ST_HALTED: begin
                // Terminal until reset; outputs keep the pipe frozen.
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    pipe_drain_timer #(
        .WIDTH      (c_DRAIN_W)
    ) u_drain_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .done_o     (w_drain_done)
    );

    assign cmd.cmd_ready = w_cmd_ready;
    assign state_o       = state_q;
    assign busy_o        = (state_q == ST_RUN) || (state_q == ST_STEP) ||
                           (state_q == ST_DRAIN);
    assign halted_o      = (state_q == ST_HALTED);

`ifdef CORE_RUN_PERF_COUNTERS_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (busy_o) begin
                cycle_cnt_q <= cycle_cnt_q + c_CNT_ONE;
            end
            if (state_q == ST_RUN && load_hazard_i && !branch_taken_i) begin
                stall_cnt_q <= stall_cnt_q + c_CNT_ONE;
            end
        end
    end

    assign cycle_count_o = cycle_cnt_q;
    assign stall_count_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire
